fir_coeff_ctrl: RTL and testbench
=================================

# fir_coeff_ctrl

Coefficient bank controller for the 15-tap transposed FIR. It accepts coefficient writes into a shadow bank over a valid/ready config port and, on commit, stalls the sample stream. It then waits for the FIR pipeline to drain, swaps the shadow bank into the active bank in one cycle, and optionally clears the FIR accumulators. It sits between the sample source and the FIR, and drives the FIR's `coeffs`, `data_in_valid` and `rst` inputs.

## Interface

Parameters:
- `NUM_COEFFS`, 15: taps per bank; sets the packed `coeffs` output depth.
- `COEFF_WIDTH`, 8: signed coefficient width.
- `DRAIN_CYCLES`, 1: cycles the sample stream is stalled before a swap; must be ≥1.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  coefficient write request.
- `cfg_ready`  out  1  write accepted when `cfg_valid && cfg_ready`.
- `cfg_addr`  in  4  tap index, 0..NUM_COEFFS-1.
- `cfg_data`  in  COEFF_WIDTH  signed coefficient value.
- `cfg_commit`  in  1  single-cycle pulse that requests a bank swap.
- `cfg_err`  out  1  one-cycle pulse on a rejected write or commit.
- `commit_done`  out  1  one-cycle pulse when the swap sequence completes.
- `busy`  out  1  high while the state is not IDLE.
- `sample_in_valid`  in  1  upstream sample strobe.
- `sample_in_ready`  out  1  high when the controller admits samples.
- `fir_in_valid`  out  1  `sample_in_valid && sample_in_ready`; combinational; drives FIR `data_in_valid`.
- `fir_rst`  out  1  FIR synchronous reset.
- `coeffs`  out  NUM_COEFFS×COEFF_WIDTH  active bank, packed `[NUM_COEFFS-1:0][COEFF_WIDTH-1:0]`, signed.

## Operation

- States: IDLE, DRAIN, SWAP, FLUSH. The FLUSH state exists only when `FIR_FLUSH_ON_SWAP_EN` is defined.
- Reset values:
  - state is IDLE;
  - shadow and active banks are all zero;
  - drain counter is 0;
  - `cfg_err`, `commit_done`, `busy` and `fir_rst` are 0;
  - `cfg_ready` and `sample_in_ready` are 1.
- Config writes:
  - `cfg_ready` is 1 in every state except SWAP.
  - An accepted write with `cfg_addr` < NUM_COEFFS stores `cfg_data` into `shadow[cfg_addr]`.
  - An accepted write with `cfg_addr` ≥ NUM_COEFFS is dropped and pulses `cfg_err` on the next cycle.
- IDLE:
  - `sample_in_ready` is 1.
  - `cfg_commit` moves the state to DRAIN and loads the drain counter with DRAIN_CYCLES.
  - A sample offered in the commit cycle is still accepted.
- DRAIN:
  - `sample_in_ready` is 0.
  - The counter decrements each cycle; the state moves to SWAP when the counter reaches 1.
- SWAP:
  - Lasts one cycle; active bank is loaded from the shadow bank as a single-cycle atomic copy of all taps.
  - The next state is FLUSH if the macro is defined, otherwise IDLE.
- FLUSH: lasts one cycle with `fir_rst` = 1; the next state is IDLE.
- `commit_done` pulses in the first IDLE cycle after SWAP or FLUSH.
- `cfg_commit` while `busy` is ignored and pulses `cfg_err` on the next cycle. No commit is queued.
- A write and a commit in the same IDLE cycle: the write lands in shadow and is included in the swap.
- Writes accepted during DRAIN or FLUSH land in shadow and take effect at the next commit only.
- The shadow bank is not cleared by a swap.
- Reset mid-sequence aborts immediately: both banks return to zero and no `commit_done` is issued.
- `coeffs` changes only in the SWAP→next transition or on reset.

## Timing

- Commit pulse at cycle t in IDLE:
  - `busy` = 1 and `sample_in_ready` = 0 from t+1.
  - DRAIN covers t+1..t+DRAIN_CYCLES.
  - SWAP is at t+DRAIN_CYCLES+1.
  - New `coeffs` are visible from t+DRAIN_CYCLES+2.
- Without the flush macro: IDLE, `commit_done` = 1 and `sample_in_ready` = 1 at t+DRAIN_CYCLES+2. Total stall is DRAIN_CYCLES+1 cycles.
- With the flush macro: `fir_rst` = 1 at t+DRAIN_CYCLES+2; IDLE and `commit_done` at t+DRAIN_CYCLES+3.
- `cfg_err` and `commit_done` are registered one-cycle pulses.
- `busy`, `cfg_ready` and `sample_in_ready` are decoded from registered state, with no combinational path from inputs.
- `fir_in_valid` is the only combinational output.

## Configuration

- `FIR_FLUSH_ON_SWAP_EN` defined: a FLUSH state follows SWAP and asserts `fir_rst` for one cycle. This clears FIR partial sums so no output mixes old and new coefficients.
- Not defined:
  - `fir_rst` is tied to 0 and the FLUSH state is removed.
  - The FIR keeps its partial sums across the swap, so up to NUM_COEFFS-1 outputs after resume blend both banks.

## Test plan

- Reset, then write taps 0..14 = 1..15 and commit at t → `coeffs` reads zero until t+3, then `coeffs[i]` = i+1. `commit_done` pulses at t+3, or at t+4 with the flush macro.
- `sample_in_valid` held high across a commit at t → `fir_in_valid` is high at t. It is low for t+1..t+2, plus t+3 with the flush macro. `fir_rst` pulses only in the flush build.
- Write `cfg_addr` = 15, `cfg_data` = 0x7F → `cfg_err` pulses for one cycle and all shadow and active taps are unchanged after a subsequent commit.
- Commit, then a second `cfg_commit` at t+1 → `cfg_err` at t+2, exactly one `commit_done`, and `busy` falls once.
- Write tap 3 = -128 with commit in the same cycle → after the swap `coeffs[3]` = -128. A write of tap 3 = 5 during DRAIN leaves active `coeffs[3]` = -128 until the next commit.
- Assert `rst` during DRAIN → all outputs return to reset values asynchronously and no `commit_done` pulse is seen.

Source files
------------

// File: rtl/fir_coeff_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_coeff_ctrl_if
//
// Purpose: bundles the configuration port, the sample-stream handshake and
// the FIR-facing outputs of the coefficient bank controller into one
// interface.
//
// Parameters (must match those of the fir_coeff_ctrl instance it connects):
//   NUM_COEFFS   taps per bank
//   COEFF_WIDTH  signed coefficient width
//
// Signals:
//   cfg_valid / cfg_ready   coefficient write handshake
//   cfg_addr, cfg_data      tap index and signed coefficient value
//   cfg_commit              single-cycle bank swap request
//   cfg_err                 one-cycle pulse on a rejected write or commit
//   commit_done             one-cycle pulse when a swap sequence completes
//   busy                    controller is not idle
//   sample_in_valid/_ready  upstream sample handshake
//   fir_in_valid            gated sample strobe towards the FIR
//   fir_rst                 FIR synchronous reset (flush)
//   coeffs                  active coefficient bank
//
// Modports:
//   master  the sample source / configuration host side
//   slave   the controller side
// ---------------------------------------------------------------------------
interface fir_coeff_ctrl_if #(
  parameter int NUM_COEFFS  = 15,
  parameter int COEFF_WIDTH = 8
);

  logic                                   cfg_valid;
  logic                                   cfg_ready;
  logic [3:0]                             cfg_addr;
  logic signed [COEFF_WIDTH-1:0]          cfg_data;
  logic                                   cfg_commit;
  logic                                   cfg_err;
  logic                                   commit_done;
  logic                                   busy;
  logic                                   sample_in_valid;
  logic                                   sample_in_ready;
  logic                                   fir_in_valid;
  logic                                   fir_rst;
  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] coeffs;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output cfg_commit,
    output sample_in_valid,
    input  cfg_ready,
    input  cfg_err,
    input  commit_done,
    input  busy,
    input  sample_in_ready,
    input  fir_in_valid,
    input  fir_rst,
    input  coeffs
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  cfg_commit,
    input  sample_in_valid,
    output cfg_ready,
    output cfg_err,
    output commit_done,
    output busy,
    output sample_in_ready,
    output fir_in_valid,
    output fir_rst,
    output coeffs
  );

endinterface

// File: rtl/fir_coeff_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coeff_ctrl
//
// Purpose: coefficient bank controller for the 15-tap transposed FIR.
// Coefficient writes land in a shadow bank. A commit stalls the sample
// stream for DRAIN_CYCLES cycles, then copies the committed shadow contents
// into the active bank in a single cycle. Optionally one further cycle pulses
// the FIR reset to clear its partial sums.
//
// Optional feature macro: FIR_FLUSH_ON_SWAP_EN
//   defined   -> a FLUSH state follows SWAP and drives fir_rst for one cycle
//   undefined -> fir_rst is tied low and the FLUSH state does not exist
//
// Parameters:
//   NUM_COEFFS    taps per bank (must match the interface instance)
//   COEFF_WIDTH   coefficient width (must match the interface instance)
//   DRAIN_CYCLES  stall cycles before the swap, must be >= 1
//
// Ports:
//   clk   rising-edge system clock
//   rst   asynchronous active-high reset
//   bus   fir_coeff_ctrl_if.slave: configuration port, sample handshake,
//         and the FIR-facing coeffs / fir_in_valid / fir_rst outputs
//
// The commit captures a snapshot of the shadow bank (including a write in
// the same cycle). The swap copies that snapshot, so writes accepted while
// the sequence is in flight stay in shadow for the next commit only.
// ---------------------------------------------------------------------------
module fir_coeff_ctrl #(
  parameter int NUM_COEFFS   = 15,
  parameter int COEFF_WIDTH  = 8,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  fir_coeff_ctrl_if.slave   bus
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  localparam logic [4:0] ADDR_LIMIT = 5'(NUM_COEFFS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_SWAP  = 2'd2;
`ifdef FIR_FLUSH_ON_SWAP_EN
  localparam logic [1:0] ST_FLUSH = 2'd3;
`endif

  typedef logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] bank_t;

  // Registered state
  logic [1:0]       state_q,       state_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  bank_t            shadow_q,      shadow_d;
  bank_t            snap_q,        snap_d;
  bank_t            active_q,      active_d;
  logic             cfg_err_q,     cfg_err_d;
  logic             commit_done_q, commit_done_d;

  // Decoded / combinational helpers
  logic             cfg_ready_s;
  logic             sample_ready_s;
  logic             busy_s;
  logic             fir_rst_s;
  logic             wr_fire_s;
  logic             addr_ok_s;
  logic             commit_idle_s;
  logic             commit_busy_s;

  // Decode the handshake-facing status from registered state only.
  always_comb begin
    cfg_ready_s    = (state_q != ST_SWAP);
    sample_ready_s = (state_q == ST_IDLE);
    busy_s         = (state_q != ST_IDLE);
`ifdef FIR_FLUSH_ON_SWAP_EN
    fir_rst_s      = (state_q == ST_FLUSH);
`else
    fir_rst_s      = 1'b0;
`endif
  end

  // Qualify the incoming write and commit requests.
  always_comb begin
    wr_fire_s     = bus.cfg_valid && cfg_ready_s;
    addr_ok_s     = ({1'b0, bus.cfg_addr} < ADDR_LIMIT);
    commit_idle_s = bus.cfg_commit && (state_q == ST_IDLE);
    commit_busy_s = bus.cfg_commit && (state_q != ST_IDLE);
  end

  // Shadow bank update; out-of-range writes are dropped.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_fire_s && addr_ok_s) begin
      shadow_d[bus.cfg_addr] = bus.cfg_data;
    end else begin
      shadow_d = shadow_q;
    end
  end

  // Error pulse: bad write address or commit while a sequence is running.
  always_comb begin
    if ((wr_fire_s && !addr_ok_s) || commit_busy_s) begin
      cfg_err_d = 1'b1;
    end else begin
      cfg_err_d = 1'b0;
    end
  end

  // Swap sequencer: IDLE -> DRAIN -> SWAP [-> FLUSH] -> IDLE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    snap_d        = snap_q;
    active_d      = active_q;
    commit_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_idle_s) begin
          state_d = ST_DRAIN;
          cnt_d   = CNT_LOAD;
          // shadow_d already holds a same-cycle write, so it joins the swap.
          snap_d  = shadow_d;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_SWAP;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_SWAP: begin
        active_d = snap_q;
`ifdef FIR_FLUSH_ON_SWAP_EN
        state_d  = ST_FLUSH;
`else
        state_d       = ST_IDLE;
        commit_done_d = 1'b1;
`endif
      end
`ifdef FIR_FLUSH_ON_SWAP_EN
      ST_FLUSH: begin
        state_d       = ST_IDLE;
        commit_done_d = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, bank and pulse registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      shadow_q      <= '0;
      snap_q        <= '0;
      active_q      <= '0;
      cfg_err_q     <= 1'b0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      snap_q        <= snap_d;
      active_q      <= active_d;
      cfg_err_q     <= cfg_err_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign bus.cfg_ready       = cfg_ready_s;
  assign bus.sample_in_ready = sample_ready_s;
  assign bus.busy            = busy_s;
  assign bus.fir_rst         = fir_rst_s;
  assign bus.cfg_err         = cfg_err_q;
  assign bus.commit_done     = commit_done_q;
  assign bus.coeffs          = active_q;
  // The only combinational path from an input to an output.
  assign bus.fir_in_valid    = bus.sample_in_valid && sample_ready_s;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
module tb_fir_coeff_ctrl;

  localparam int NC = 15;
  localparam int CW = 8;
  localparam int DC = 1;
`ifdef FIR_FLUSH_ON_SWAP_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef logic [NC-1:0][CW-1:0] bank_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fir_coeff_ctrl_if #(.NUM_COEFFS(NC), .COEFF_WIDTH(CW)) bus ();

  fir_coeff_ctrl #(.NUM_COEFFS(NC), .COEFF_WIDTH(CW), .DRAIN_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  int    fall_cnt = 0;
  bit    busy_prev = 1'b0;
  bank_t shadow_m = '0;
  bank_t active_m = '0;
  bank_t exp_q[$];

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input bank_t obs, input bank_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each commit_done pops the bank expected from that commit.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.commit_done === 1'b1) begin
        done_cnt++;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_unexpected_done: observed pulse expected none (queue empty)");
        end
        if (exp_q.size() > 0) chkb("sb_coeffs", bus.coeffs, exp_q.pop_front());
      end
      if (busy_prev && (bus.busy === 1'b0)) fall_cnt++;
      busy_prev = (bus.busy === 1'b1);
    end else begin
      busy_prev = 1'b0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    if (a < 4'(NC)) shadow_m[a] = d;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cfg_ready"},    bus.cfg_ready,       1'b1);
    chk({tag, "_sample_ready"}, bus.sample_in_ready, 1'b1);
    chk({tag, "_busy"},         bus.busy,            1'b0);
    chk({tag, "_cfg_err"},      bus.cfg_err,         1'b0);
    chk({tag, "_commit_done"},  bus.commit_done,     1'b0);
    chk({tag, "_fir_rst"},      bus.fir_rst,         1'b0);
    chkb({tag, "_coeffs"},      bus.coeffs,          '0);
  endtask

  // Full commit sequence with cycle-exact checks. Optional write in the
  // commit cycle, optional write in the first DRAIN cycle, optional second
  // commit in the first DRAIN cycle.
  task automatic commit_seq(input bit wr_same, input logic [3:0] wa, input logic [7:0] wd,
                            input bit wr_drain, input logic [3:0] da, input logic [7:0] dd,
                            input bit dbl);
    bank_t snap;
    bus.cfg_commit      = 1'b1;
    bus.sample_in_valid = 1'b1;
    if (wr_same) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_addr  = wa;
      bus.cfg_data  = wd;
      if (wa < 4'(NC)) shadow_m[wa] = wd;
    end
    snap = shadow_m;
    exp_q.push_back(snap);
    #1;
    chk("fir_in_valid_commit_cycle", bus.fir_in_valid, 1'b1);
    tick();
    bus.cfg_commit = 1'b0;
    bus.cfg_valid  = 1'b0;
    for (int k = 1; k <= DC; k++) begin
      if (k == 1 && dbl) bus.cfg_commit = 1'b1;
      if (k == 1 && wr_drain) begin
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = da;
        bus.cfg_data  = dd;
        if (da < 4'(NC)) shadow_m[da] = dd;
      end
      chk("drain_busy",         bus.busy,            1'b1);
      chk("drain_sample_ready", bus.sample_in_ready, 1'b0);
      chk("drain_fir_in_valid", bus.fir_in_valid,    1'b0);
      chk("drain_cfg_ready",    bus.cfg_ready,       1'b1);
      chk("drain_cfg_err",      bus.cfg_err,         dbl && (k == 2));
      chkb("drain_coeffs_old",  bus.coeffs,          active_m);
      tick();
      bus.cfg_commit = 1'b0;
      bus.cfg_valid  = 1'b0;
    end
    // SWAP cycle (t+DC+1)
    chk("swap_cfg_ready",    bus.cfg_ready,    1'b0);
    chk("swap_busy",         bus.busy,         1'b1);
    chk("swap_fir_in_valid", bus.fir_in_valid, 1'b0);
    chk("swap_commit_done",  bus.commit_done,  1'b0);
    chk("swap_cfg_err",      bus.cfg_err,      dbl && (DC + 1 == 2));
    chkb("swap_coeffs_old",  bus.coeffs,       active_m);
    tick();
    // t+DC+2: FLUSH in the flush build, final IDLE otherwise
    chk("post_swap_fir_rst",      bus.fir_rst,      FLUSH);
    chk("post_swap_commit_done",  bus.commit_done,  !FLUSH);
    chk("post_swap_busy",         bus.busy,         FLUSH);
    chk("post_swap_fir_in_valid", bus.fir_in_valid, !FLUSH);
    chkb("post_swap_coeffs_new",  bus.coeffs,       snap);
    if (FLUSH) tick();
    chk("done_commit_done",  bus.commit_done,     1'b1);
    chk("done_busy",         bus.busy,            1'b0);
    chk("done_sample_ready", bus.sample_in_ready, 1'b1);
    chk("done_fir_in_valid", bus.fir_in_valid,    1'b1);
    chk("done_fir_rst",      bus.fir_rst,         1'b0);
    chkb("done_coeffs_new",  bus.coeffs,          snap);
    active_m = snap;
    bus.sample_in_valid = 1'b0;
    tick();
    chk("done_pulse_one_cycle", bus.commit_done, 1'b0);
    chkb("coeffs_stable",       bus.coeffs,      active_m);
  endtask

  initial begin : stim
    int d0;
    int f0;
    bus.cfg_valid       = 1'b0;
    bus.cfg_addr        = 4'd0;
    bus.cfg_data        = 8'd0;
    bus.cfg_commit      = 1'b0;
    bus.sample_in_valid = 1'b0;
    #1 rst = 1'b1;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Taps 0..14 = 1..15, then commit
    for (int i = 0; i < NC; i++) wr(4'(i), 8'(i + 1));
    commit_seq(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
    chkb("bank_1_to_15_tap14", bus.coeffs, shadow_m);

    // Out-of-range write is dropped and flagged
    wr(4'd15, 8'h7F);
    chk("bad_addr_cfg_err", bus.cfg_err, 1'b1);
    tick();
    chk("bad_addr_cfg_err_one_cycle", bus.cfg_err, 1'b0);
    commit_seq(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);

    // Second commit while busy: error, single completion, busy falls once
    d0 = done_cnt;
    f0 = fall_cnt;
    commit_seq(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b1);
    tick();
    tick();
    chki("dbl_commit_done_count", done_cnt - d0, 1);
    chki("dbl_commit_busy_falls", fall_cnt - f0, 1);

    // Write with commit in the same cycle, then a DRAIN write to the same tap
    commit_seq(1'b1, 4'd3, 8'h80, 1'b1, 4'd3, 8'd5, 1'b0);
    chk("tap3_neg128_bit7", bus.coeffs[3][7], 1'b1);
    tick();
    chkb("tap3_held_after_drain_write", bus.coeffs, active_m);
    // The DRAIN write becomes active at the next commit
    commit_seq(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
    chk("tap3_now_5_bit0", bus.coeffs[3][0], 1'b1);
    chk("tap3_now_5_bit7", bus.coeffs[3][7], 1'b0);

    // Reset during DRAIN aborts immediately with no completion
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    chk("pre_abort_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset("abort");
    exp_q.delete();
    shadow_m = '0;
    active_m = '0;
    d0 = done_cnt;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chki("abort_no_commit_done", done_cnt - d0, 0);
    check_reset("after_abort");

    // Shadow was cleared by reset: only the new tap appears
    wr(4'd7, 8'h11);
    commit_seq(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 8'd0, 1'b0);
    chki("sb_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
